// File: rtl/hf_pkg.sv
// Shared types and constants for the half-adder cell family.
package hf_pkg;

  localparam logic HF_RST_VAL = 1'b0;

  typedef struct packed {
    logic cout;
    logic sum;
  } hf_res_t;

endpackage : hf_pkg

// File: rtl/hf_gate_if.sv
// Operand/result bundle for hf_gate; parents wire these onto the plain ports.
interface hf_gate_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cout;

  modport master (output a, output b, input  sum, input  cout);
  modport slave  (input  a, input  b, output sum, output cout);
endinterface : hf_gate_if

// File: rtl/hf_cell.sv
// One half-adder lane built from gate primitives only.
module hf_cell (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);

  xor u_xor (sum_o, a_i, b_i);
  and u_and (cout_o, a_i, b_i);

endmodule : hf_cell

// File: rtl/hf_gate.sv
// WIDTH independent half-adder lanes, optionally registered with synchronous reset.
module hf_gate
  import hf_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] cout_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    hf_cell u_cell (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .sum_o  (sum_d[i]),
      .cout_o (cout_d[i])
    );
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q  <= {WIDTH{HF_RST_VAL}};
        cout_q <= {WIDTH{HF_RST_VAL}};
      end else begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
  end else begin : g_comb
    // clk/rst are intentionally dead in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign sum  = sum_d;
    assign cout = cout_d;
  end

endmodule : hf_gate

// File: tb/tb_hf_gate.sv
// Self-checking bench for hf_gate: arithmetic lane model plus hand-computed pins.
module tb_hf_gate;
  import hf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hf_gate_if #(.WIDTH(1)) if1 ();
  hf_gate_if #(.WIDTH(4)) if4 ();
  hf_gate_if #(.WIDTH(8)) if8 ();
  hf_gate_if #(.WIDTH(1)) ifc ();

  hf_gate #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .a(if1.a), .b(if1.b), .sum(if1.sum), .cout(if1.cout));
  hf_gate #(.WIDTH(4), .REGISTERED(1'b1)) u_r4 (
    .clk(clk), .rst(rst), .a(if4.a), .b(if4.b), .sum(if4.sum), .cout(if4.cout));
  hf_gate #(.WIDTH(8), .REGISTERED(1'b1)) u_r8 (
    .clk(clk), .rst(rst), .a(if8.a), .b(if8.b), .sum(if8.sum), .cout(if8.cout));
  hf_gate #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .a(ifc.a), .b(ifc.b), .sum(ifc.sum), .cout(ifc.cout));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each lane's 2-bit result is the integer sum of its two bits.
  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv,
                                        input logic r);
    logic [7:0] s;
    logic [7:0] c;
    s = '0;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      int t;
      t = r ? 0 : int'(av[i]) + int'(bv[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  logic       m_valid = 1'b0;
  logic [7:0] e1_s, e1_c, e4_s, e4_c, e8_s, e8_c;

  always @(posedge clk) begin
    logic [15:0] r1, r4, r8;
    r1 = model({7'd0, if1.a}, {7'd0, if1.b}, rst);
    r4 = model({4'd0, if4.a}, {4'd0, if4.b}, rst);
    r8 = model(if8.a, if8.b, rst);
    m_valid <= 1'b1;
    {e1_c, e1_s} <= r1;
    {e4_c, e4_s} <= r4;
    {e8_c, e8_s} <= r8;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("w1_sum",   {7'd0, if1.sum},  e1_s);
      chk("w1_cout",  {7'd0, if1.cout}, e1_c);
      chk("w4_sum",   {4'd0, if4.sum},  e4_s);
      chk("w4_cout",  {4'd0, if4.cout}, e4_c);
      chk("w8_sum",   if8.sum,  e8_s);
      chk("w8_cout",  if8.cout, e8_c);
      chk("w8_excl",  if8.sum & if8.cout, 8'd0);
    end
  end

  task automatic step(input logic r, input logic av, input logic bv);
    @(negedge clk);
    rst   = r;
    if1.a = av;
    if1.b = bv;
    if4.a = 4'($urandom);
    if4.b = 4'($urandom);
    if8.a = 8'($urandom);
    if8.b = 8'($urandom);
  endtask

  function automatic logic [7:0] r1_pair();
    return {6'd0, if1.cout, if1.sum};
  endfunction

  initial begin
    logic [1:0] tt [4];
    tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b01; tt[3] = 2'b10;

    rst = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0;
    if4.a = '0;   if4.b = '0;
    if8.a = '0;   if8.b = '0;

    // Combinational build: same-delta truth table, no clock involved.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] v;
      v = 2'(i);
      ifc.a = v[1];
      ifc.b = v[0];
      #1;
      chk("comb_tt", {6'd0, ifc.cout, ifc.sum}, {6'd0, tt[i]});
    end

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_state", r1_pair(), 8'd0);

    // Truth table through the registered lane, one operand pair per cycle.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1); chk("tt_00", r1_pair(), {6'd0, tt[0]});
    step(1'b0, 1'b1, 1'b0); chk("tt_01", r1_pair(), {6'd0, tt[1]});
    step(1'b0, 1'b1, 1'b1); chk("tt_10", r1_pair(), {6'd0, tt[2]});
    step(1'b0, 1'b0, 1'b0); chk("tt_11", r1_pair(), {6'd0, tt[3]});

    // Reset held three cycles with a=b=1.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1); chk("hold_rst0", r1_pair(), 8'd0);
    step(1'b1, 1'b1, 1'b1); chk("hold_rst1", r1_pair(), 8'd0);
    step(1'b0, 1'b1, 1'b1); chk("hold_rst2", r1_pair(), 8'd0);
    step(1'b0, 1'b0, 1'b0); chk("release",   r1_pair(), 8'b10);

    // One-cycle reset pulse mid-stream; the operand under reset is discarded.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1); chk("mid_pre",   r1_pair(), 8'b01);
    step(1'b0, 1'b1, 1'b0); chk("mid_rst",   r1_pair(), 8'b00);
    step(1'b0, 1'b1, 1'b1); chk("mid_next",  r1_pair(), 8'b01);
    step(1'b0, 1'b0, 1'b0); chk("mid_last",  r1_pair(), 8'b10);

    // Four lanes, no carry between lanes.
    step(1'b0, 1'b0, 1'b0);
    if4.a = 4'b1100;
    if4.b = 4'b1010;
    step(1'b0, 1'b0, 1'b0);
    chk("w4_lit_sum",  {4'd0, if4.sum},  8'b0110);
    chk("w4_lit_cout", {4'd0, if4.cout}, 8'b1000);

    for (int n = 0; n < 1000; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom));
    end
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hf_gate
